// File: rtl/rv_mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// BITS_PER_CYCLE bits per step. Optional early-out special cases: RV_MDU_EARLY_OUT_EN.
module rv_mdu #(
  parameter int DPWIDTH        = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         op,
  input  logic [DPWIDTH-1:0] opa,
  input  logic [DPWIDTH-1:0] opb,
  output logic               busy,
  output logic               done,
  output logic [DPWIDTH-1:0] result
);

  localparam int W  = DPWIDTH;
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = W / B;
  localparam int CW = $clog2(N + 1);
  localparam logic [W-1:0] MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO     = {W{1'b0}};

  if ((B != 1 && B != 2 && B != 4) || (W % B != 0) || (W % 2 != 0)) begin : g_param_check
    $error("rv_mdu: illegal DPWIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [2:0]     r_op;
  logic [2*W-1:0] r_acc;     // product {hi,lo} or {unused, dividend/quotient}
  logic [W:0]     r_rem;
  logic [W-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic           r_neg_q;
  logic           r_neg_r;
  logic           r_special;
  logic [W-1:0]   r_spec_val;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_result;

  logic           w_a_signed, w_b_signed, w_sa, w_sb;
  logic [W-1:0]   w_ma, w_mb;
  logic           w_special;
  logic [W-1:0]   w_spec_val;
  logic [W+B-1:0] w_sum;
  logic [2*W+B-1:0] w_wide;
  logic [W:0]     w_rem;
  logic [W-1:0]   w_quo;
  logic [2*W-1:0] w_acc_nxt;
  logic [W:0]     w_rem_nxt;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]   w_quo_fix, w_rem_fix, w_fix;
  logic           w_accept;

  assign w_accept = (r_state == S_IDLE) && start && !abort;

  // Operand signedness and magnitudes
  always_comb begin
    w_a_signed = op[2] ? !op[0] : (op != 3'd3);
    w_b_signed = op[2] ? !op[0] : !op[1];
    w_sa = w_a_signed && opa[W-1];
    w_sb = w_b_signed && opb[W-1];
    w_ma = w_sa ? (~opa + 1'b1) : opa;
    w_mb = w_sb ? (~opb + 1'b1) : opb;
  end

  // Cases resolved directly in FIX without iterating
  always_comb begin
    w_special  = 1'b0;
    w_spec_val = ZERO;
    if (op[2] && (opb == ZERO)) begin
      w_special  = 1'b1;
      w_spec_val = op[1] ? opa : ALL_ONES;
    end else if (op[2] && !op[0] && (opa == MIN_NEG) && (opb == ALL_ONES)) begin
      w_special  = 1'b1;
      w_spec_val = op[1] ? ZERO : opa;
`ifdef RV_MDU_EARLY_OUT_EN
    end else if ((opa == ZERO) || (!op[2] && (opb == ZERO))) begin
      w_special  = 1'b1;
      w_spec_val = ZERO;
    end else if (op[2] && op[0] && (opa < opb)) begin
      w_special  = 1'b1;
      w_spec_val = op[1] ? opa : ZERO;
`endif
    end else begin
      w_special  = 1'b0;
      w_spec_val = ZERO;
    end
  end

  // One iteration: B shift-add steps or B restoring-divide steps
  always_comb begin
    w_sum     = {(W+B){1'b0}};
    w_wide    = {(2*W+B){1'b0}};
    w_rem     = r_rem;
    w_quo     = r_acc[W-1:0];
    w_acc_nxt = r_acc;
    w_rem_nxt = r_rem;
    if (!r_op[2]) begin
      w_sum = {{B{1'b0}}, r_acc[2*W-1:W]};
      for (int j = 0; j < B; j++) begin
        w_sum = w_sum + (r_acc[j] ? ({{B{1'b0}}, r_opnd} << j) : {(W+B){1'b0}});
      end
      w_wide    = {w_sum, r_acc[W-1:0]} >> B;
      w_acc_nxt = w_wide[2*W-1:0];
    end else begin
      for (int j = 0; j < B; j++) begin
        w_rem = {w_rem[W-1:0], w_quo[W-1]};
        w_quo = {w_quo[W-2:0], 1'b0};
        if (w_rem >= {1'b0, r_opnd}) begin
          w_rem    = w_rem - {1'b0, r_opnd};
          w_quo[0] = 1'b1;
        end else begin
          w_quo[0] = 1'b0;
        end
      end
      w_acc_nxt = {r_acc[2*W-1:W], w_quo};
      w_rem_nxt = w_rem;
    end
  end

  // Sign correction and result selection
  always_comb begin
    w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo_fix  = r_neg_q ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
    w_rem_fix  = r_neg_r ? (~r_rem[W-1:0] + 1'b1) : r_rem[W-1:0];
    if (r_special) begin
      w_fix = r_spec_val;
    end else begin
      case (r_op)
        3'd0:          w_fix = w_prod_fix[W-1:0];
        3'd1, 3'd2,
        3'd3:          w_fix = w_prod_fix[2*W-1:W];
        3'd4, 3'd5:    w_fix = w_quo_fix;
        3'd6, 3'd7:    w_fix = w_rem_fix;
        default:       w_fix = ZERO;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_next = w_special ? S_FIX : S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_next = S_FIX;
        end else begin
          w_next = S_RUN;
        end
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= 3'd0;
      r_acc      <= {(2*W){1'b0}};
      r_rem      <= {(W+1){1'b0}};
      r_opnd     <= ZERO;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= ZERO;
      r_cnt      <= {CW{1'b0}};
      r_result   <= ZERO;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op       <= op;
            r_acc      <= {ZERO, (op[2] ? w_ma : w_mb)};
            r_rem      <= {(W+1){1'b0}};
            r_opnd     <= op[2] ? w_mb : w_ma;
            r_neg_q    <= w_sa ^ w_sb;
            r_neg_r    <= w_sa;
            r_special  <= w_special;
            r_spec_val <= w_spec_val;
            r_cnt      <= CW'(N);
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (!abort) begin
            r_result <= w_fix;
          end
        end
        default: r_cnt <= {CW{1'b0}};
      endcase
    end
  end

  // done and the fresh result are visible in the FIX cycle itself; abort there suppresses both
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_FIX) && !abort;
  assign result = done ? w_fix : r_result;

endmodule

// File: tb/tb_rv_mdu.sv
// Self-checking bench for rv_mdu: arithmetic reference model plus per-cycle compare,
// and directed vectors with hand-computed results.
module tb_rv_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] opa = 32'd0;
  logic [31:0] opb = 32'd0;
  logic        busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  rv_mdu #(.DPWIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
    .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Architectural result of an RV32M operation
  function automatic logic [31:0] exp_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    case (f)
      3'd0: begin p = longint'(int'(a)) * longint'(int'(b)); return p[31:0]; end
      3'd1: begin p = longint'(int'(a)) * longint'(int'(b)); return p[63:32]; end
      3'd2: begin p = longint'(int'(a)) * longint'({32'h0, b}); return p[63:32]; end
      3'd3: begin u = {32'h0, a} * {32'h0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(int'(a) / int'(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(int'(a) % int'(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Cycles from the start cycle to the done cycle
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RV_MDU_EARLY_OUT_EN
    if (a == 32'd0) return 1;
    if (!f[2] && b == 32'd0) return 1;
    if ((f == 3'd5 || f == 3'd7) && a < b) return 1;
`endif
    return 33;
  endfunction

  // Reference model: busy window, done cycle, committed result
  logic        m_busy = 1'b0;
  int          m_left = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_result = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_left   <= 0;
      m_pend   <= 32'd0;
      m_result <= 32'd0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        m_busy <= 1'b1;
        m_left <= exp_lat(op, opa, opb);
        m_pend <= exp_res(op, opa, opb);
      end
    end else if (abort || m_left == 1) begin
      m_busy <= 1'b0;
      if (!abort) m_result <= m_pend;
    end else begin
      m_left <= m_left - 1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic e_done;
    if (!rst) begin
      e_done = m_busy && (m_left == 1) && !abort;
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, e_done});
      chk("result", result, e_done ? m_pend : m_result);
    end
  end

  task automatic issue_and_wait(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                output int cycles, output logic [31:0] res);
    @(posedge clk); #1;
    start = 1'b1; op = f; opa = a; opb = b;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    res = result;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout op=%0d a=%h b=%h: no done within %0d cycles", f, a, b, cycles);
    end
  endtask

  task automatic run_lit(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit, input int lat);
    int cyc;
    logic [31:0] res;
    issue_and_wait(f, a, b, cyc, res);
    chk({name, "_lat"}, 32'(cyc), 32'(lat));
    chk(name, res, lit);
  endtask

  task automatic run_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic [31:0] res;
    issue_and_wait(f, a, b, cyc, res);
    chk("rand_lat", 32'(cyc), 32'(exp_lat(f, a, b)));
    chk("rand_res", res, exp_res(f, a, b));
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int   ndone;
    logic saw_done;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    run_lit("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_lit("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_lit("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_lit("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_lit("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_lit("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_lit("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_lit("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_lit("divu_5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_lit("rem_5/0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_lit("mul_3x4", 3'd0, 32'd3, 32'd4, 32'd12, 33);

    // DIVU with a stray start at t+5 and abort at t+10
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; opa = 32'd1000; opb = 32'd3;
    saw_done = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      start = (k == 5);
      if (k == 5) begin op = 3'd0; opa = 32'd9; opb = 32'd9; end
      abort = (k == 10);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    chk("abort_busy_low", {31'd0, busy}, 32'd0);
    chk("abort_result_kept", result, 32'd12);
    run_lit("divu_after_abort", 3'd5, 32'd1000, 32'd3, 32'd333, 33);

    // start held through a special-case FIX cycle: accepted, ignored, accepted again
    @(posedge clk); #1;
    start = 1'b1; op = 3'd5; opa = 32'd5; opb = 32'd0;
    ndone = 0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) start = 1'b0;
      if (done) ndone++;
    end
    chk("start_in_fix_dones", 32'(ndone), 32'd2);

    // asynchronous reset mid-RUN
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
    chk("midrun_rst_done", {31'd0, done}, 32'd0);
    chk("midrun_rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_lit("mul_0x5", 3'd0, 32'd0, 32'd5, 32'd0, exp_lat(3'd0, 32'd0, 32'd5));
    run_lit("divu_3/9", 3'd5, 32'd3, 32'd9, 32'd0, exp_lat(3'd5, 32'd3, 32'd9));
    run_lit("remu_3/9", 3'd7, 32'd3, 32'd9, 32'd3, exp_lat(3'd7, 32'd3, 32'd9));

    for (int i = 0; i < 24; i++) begin
      run_model(3'($urandom_range(0, 7)), pick($urandom_range(0, 5)), pick($urandom_range(0, 5)));
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
